namuru_accum_bank: RTL

- Parametrised multi-channel accumulation dump bank with a WISHBONE slave port; the next-generation register front end for the Namuru GPS correlator.
- Latches per-channel I/Q integrations on each dump strobe and tracks new-data and missed-dump status per channel.
- Drives the accum_int interrupt and serves everything to the CPU with a configurable ack latency.
- Single clock domain: the correlator and this bank share one clock.

---
 rtl/namuru_accum_bank.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/namuru_accum_bank.sv
// Namuru correlator accumulation dump bank with WISHBONE slave port.
// Optional NAMURU_DUMP_TIMESTAMP_EN latches a free-running cycle count per dump.
module namuru_accum_bank #(
    parameter int NCH      = 12,
    parameter int ACCW     = 16,
    parameter int ACK_WAIT = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [31:0]         wb_adr_i,
    output logic [31:0]         wb_dat_o,
    input  logic [31:0]         wb_dat_i,
    input  logic [3:0]          wb_sel_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic                wb_ack_o,
    input  logic                wb_we_i,
    input  logic [NCH-1:0]      dump_i,
    input  logic [NCH*ACCW-1:0] acc_i_i,
    input  logic [NCH*ACCW-1:0] acc_q_i,
    output logic                accum_int
);
    localparam logic [31:0] ID = {8'h4E, 8'(NCH), 8'(ACCW), 8'(ACK_WAIT)};

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      wcnt_q, wcnt_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;
    logic            stat_rd_q, stat_rd_d;
    logic            int_q, int_d;
    logic [ACCW-1:0] i_q [NCH];
    logic [ACCW-1:0] i_d [NCH];
    logic [ACCW-1:0] q_q [NCH];
    logic [ACCW-1:0] q_d [NCH];
    logic [15:0]     cnt_q [NCH];
    logic [15:0]     cnt_d [NCH];
    logic [NCH-1:0]  status_q, status_d;
    logic [NCH-1:0]  missed_q, missed_d;
    logic [NCH-1:0]  mask_q, mask_d;

    logic            req, fire, wr;
    logic [7:0]      word;
    logic [5:0]      ch;
    logic [31:0]     bmask, rd_data;
    logic [NCH-1:0]  clr;
    logic            unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    assign word       = wb_adr_i[9:2];
    assign ch         = word[7:2];
    assign unused_adr = ^{wb_adr_i[31:10], wb_adr_i[1:0]};
    assign bmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                         {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign fire       = (state_q == S_WAIT) && req && (wcnt_q == 3'd0);
    assign wr         = fire && wb_we_i;

`ifdef NAMURU_DUMP_TIMESTAMP_EN
    logic [31:0] tmr_q, tmr_d;
    logic [31:0] ts_q [NCH];
    logic [31:0] ts_d [NCH];

    always_comb begin
        tmr_d = tmr_q + 32'd1;
        ts_d  = ts_q;
        for (int c = 0; c < NCH; c++) begin
            if (dump_i[c]) ts_d[c] = tmr_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tmr_q <= '0;
            for (int c = 0; c < NCH; c++) ts_q[c] <= '0;
        end else begin
            tmr_q <= tmr_d;
            ts_q  <= ts_d;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        if (word == 8'hF0) rd_data = 32'(status_q);
        else if (word == 8'hF1) rd_data = 32'(missed_q);
        else if (word == 8'hF2) rd_data = 32'(mask_q);
        else if (word == 8'hF3) rd_data = ID;
        else begin
            for (int c = 0; c < NCH; c++) begin
                if (int'(ch) == c) begin
                    case (word[1:0])
                        2'd0:    rd_data = 32'($signed(i_q[c]));
                        2'd1:    rd_data = 32'($signed(q_q[c]));
                        2'd2:    rd_data = 32'(cnt_q[c]);
`ifdef NAMURU_DUMP_TIMESTAMP_EN
                        default: rd_data = ts_q[c];
`else
                        default: rd_data = '0;
`endif
                    endcase
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        stat_rd_d = 1'b0;
        i_d       = i_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        status_d  = status_q;
        mask_d    = mask_q;
        int_d     = |(status_q & mask_q);

        case (state_q)
            S_IDLE: begin
                if (req && !ack_q) begin
                    state_d = S_WAIT;
                    wcnt_d  = 3'(ACK_WAIT);
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == 3'd0) begin
                    state_d   = S_IDLE;
                    ack_d     = 1'b1;
                    dat_d     = rd_data;
                    stat_rd_d = !wb_we_i && (word == 8'hF0);
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        clr = (wr && word == 8'hF1) ? NCH'(wb_dat_i & bmask) : '0;
        if (wr && word == 8'hF2)
            mask_d = NCH'((32'(mask_q) & ~bmask) | (wb_dat_i & bmask));

        // Clear only what the CPU saw; dumps landing in the ack cycle survive
        if (ack_q && stat_rd_q) status_d = status_q & ~NCH'(dat_q);

        missed_d = missed_q & ~clr;
        for (int c = 0; c < NCH; c++) begin
            if (dump_i[c]) begin
                if (status_q[c]) missed_d[c] = 1'b1;
                status_d[c] = 1'b1;
                i_d[c]      = acc_i_i[c*ACCW +: ACCW];
                q_d[c]      = acc_q_i[c*ACCW +: ACCW];
                cnt_d[c]    = cnt_q[c] + 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            stat_rd_q <= 1'b0;
            int_q     <= 1'b0;
            status_q  <= '0;
            missed_q  <= '0;
            mask_q    <= '0;
            for (int c = 0; c < NCH; c++) begin
                i_q[c]   <= '0;
                q_q[c]   <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            stat_rd_q <= stat_rd_d;
            int_q     <= int_d;
            status_q  <= status_d;
            missed_q  <= missed_d;
            mask_q    <= mask_d;
            i_q       <= i_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign accum_int = int_q;

endmodule
